// File: rtl/deserializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// deserializer
//
// Collects a serial bit stream (MSB first) into a WIDTH-bit parallel word and
// hands the finished word to a downstream register through data_out/load.
//
// Build option: define DESERIALIZER_PARITY_EN to add a PARITY state that
// takes one extra even-parity bit after the data bits. Without the macro,
// frames are exactly WIDTH bits and parity_err is tied to 0.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : asynchronous active-low reset
//   start      : frame-start strobe (restarts a frame in progress)
//   bit_valid  : qualifies bit_in for the current cycle
//   bit_in     : serial data, MSB first
//   data_out   : last completed word (changes only on entry to DONE)
//   load       : one-cycle strobe, high while in DONE
//   busy       : high while a frame is being received (SHIFT/PARITY)
//   frame_err  : one-cycle pulse after start aborted a frame in progress
//   parity_err : one-cycle pulse after a parity mismatch (0 without parity)
//   state_dbg  : current FSM state encoding, for debug/checkers
//
// Handshake: the serial side has no back-pressure. A bit is taken on every
// rising edge where bit_valid=1 and the FSM is in SHIFT (or PARITY) and start
// is low; start always wins over bit_valid in the same cycle. The parallel
// side sees load=1 for exactly one cycle with data_out already holding the word.
// -----------------------------------------------------------------------------
module deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [WIDTH-1:0] data_out,
   output logic             load,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef DESERIALIZER_PARITY_EN
      PARITY = 2'd2,
`endif
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] word_next;
   logic             frame_err_d;

   // Word as it will look once the current bit_in is shifted in.
   assign word_next = {shift_q[WIDTH-2:0], bit_in};

`ifdef DESERIALIZER_PARITY_EN
   logic parity_err_d;
`endif

   // -------------------------------------------------------------------------
   // Next-state / datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      data_d      = data_out;
      frame_err_d = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // bit_valid is ignored here, including a bit arriving with start.
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end

         SHIFT: begin
            if (start) begin
               // Abort and restart; the bit of this cycle is dropped.
               frame_err_d = 1'b1;
               cnt_d       = '0;
               shift_d     = '0;
            end else if (bit_valid) begin
               shift_d = word_next;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST_IDX) begin
`ifdef DESERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = DONE;
                  data_d  = word_next;
`endif
               end
            end
         end

`ifdef DESERIALIZER_PARITY_EN
         PARITY: begin
            if (start) begin
               frame_err_d = 1'b1;
               state_d     = SHIFT;
               cnt_d       = '0;
               shift_d     = '0;
            end else if (bit_valid) begin
               // Even parity: XOR of data bits and parity bit must be 0.
               if (((^shift_q) ^ bit_in) == 1'b0) begin
                  state_d = DONE;
                  data_d  = shift_q;
               end else begin
                  parity_err_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
`endif

         DONE: begin
            // The load happens this cycle regardless; start chains a new frame.
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         data_out  <= '0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         data_out  <= data_d;
         frame_err <= frame_err_d;
      end
   end

`ifdef DESERIALIZER_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_err_d;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Outputs decoded from state (reset forces IDLE, so these clear at once)
   // -------------------------------------------------------------------------
   assign load = (state_q == DONE);
`ifdef DESERIALIZER_PARITY_EN
   assign busy = (state_q == SHIFT) || (state_q == PARITY);
`else
   assign busy = (state_q == SHIFT);
`endif
   assign state_dbg = state_q;

endmodule

// File: tb/tb_deserializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_deserializer
//
// Directed steps for the documented scenarios followed by randomized frames
// (random words, random bit_valid gaps, random aborts). Expected words are
// queued per frame and matched against every load pulse seen on the DUT.
// -----------------------------------------------------------------------------
module tb_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         bit_valid = 1'b0;
   logic         bit_in = 1'b0;
   logic [W-1:0] data_out;
   logic         load;
   logic         busy;
   logic         frame_err;
   logic         parity_err;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int load_seen = 0;
   int ferr_seen = 0;
   int perr_seen = 0;
   int exp_loads = 0;
   int exp_ferr  = 0;
   int exp_perr  = 0;

   logic [W-1:0] last_word = '0;
   logic [W-1:0] exp_q[$];

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   deserializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .data_out   (data_out),
      .load       (load),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .state_dbg  (state_dbg)
   );

   // ---------------------------------------------------------------- checker
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   // Every load must match the oldest word the bench finished sending.
   always @(negedge clk) begin
      if (load === 1'b1) begin
         load_seen++;
         if (exp_q.size() == 0)
            chk("load_unexpected", 32'(load), 32'd0);
         else
            chk("load_word", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (parity_err === 1'b1) perr_seen++;
   end

   // ---------------------------------------------------------------- drivers
   task automatic drive_cycle(input logic s, input logic v, input logic b);
      start     = s;
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      #1;
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   // Cycles with random bit_valid/bit_in; only used while the DUT is not in a frame.
   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic gap(input int min_gap, input int max_gap);
      repeat ($urandom_range(min_gap, max_gap)) drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
   endtask

   // Start a frame and send word w; 'aborting' says the start lands mid-frame.
   task automatic send_frame(input logic [W-1:0] w, input int min_gap, input int max_gap,
                             input logic aborting);
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("frame_err_on_start", 32'(frame_err), 32'(aborting));
      if (aborting) exp_ferr++;
      for (int i = W - 1; i >= 0; i--) begin
         if (i != W - 1) gap(min_gap, max_gap);
`ifndef DESERIALIZER_PARITY_EN
         if (i == 0) begin
            chk("no_early_load", 32'(load), 32'd0);
            chk("data_hold", 32'(data_out), 32'(last_word));
            exp_q.push_back(w);
         end
`endif
         drive_cycle(1'b0, 1'b1, w[i]);
      end
`ifdef DESERIALIZER_PARITY_EN
      gap(min_gap, max_gap);
      chk("no_early_load", 32'(load), 32'd0);
      chk("data_hold", 32'(data_out), 32'(last_word));
      exp_q.push_back(w);
      drive_cycle(1'b0, 1'b1, ^w);
`endif
      chk("load_latency", 32'(load), 32'd1);
      chk("load_data", 32'(data_out), 32'(w));
      last_word = w;
      exp_loads++;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [W-1:0] w;
      logic         ab;

      // Reset state, checked before any clock edge.
      #2;
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_load", 32'(load), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_parity_err", 32'(parity_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // First edge out of reset behaves as IDLE: bit_valid ignored.
      drive_cycle(1'b0, 1'b1, 1'b1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_data", 32'(data_out), 32'd0);

      // 0x55 on consecutive cycles.
      send_frame(8'h55, 0, 0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      chk("55_load_one_cycle", 32'(load), 32'd0);
      chk("55_busy_after", 32'(busy), 32'd0);
      chk("55_data_held", 32'(data_out), 32'h55);

      // 0xAA with bit_valid gaps between bits.
      send_frame(8'hAA, 1, 3, 1'b0);
      idle(1);
      chk("aa_data_held", 32'(data_out), 32'hAA);

      // Abort after 4 bits of 0xFF, then a full 0x0F frame.
      drive_cycle(1'b1, 1'b0, 1'b0);
      repeat (4) drive_cycle(1'b0, 1'b1, 1'b1);
      send_frame(8'h0F, 0, 0, 1'b1);
      idle(1);
      chk("abort_data", 32'(data_out), 32'h0F);

      // Reset mid-frame after 5 bits of 0xFF.
      drive_cycle(1'b1, 1'b0, 1'b0);
      repeat (5) drive_cycle(1'b0, 1'b1, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_data_out", 32'(data_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_load", 32'(load), 32'd0);
      last_word = '0;
      @(negedge clk);
      rst = 1'b1;
      idle(4);
      chk("midrst_no_load_data", 32'(data_out), 32'd0);
      chk("midrst_idle_busy", 32'(busy), 32'd0);

      // Back-to-back: start during the DONE cycle of 0x55, then 0xAA.
      send_frame(8'h55, 0, 0, 1'b0);
      send_frame(8'hAA, 0, 0, 1'b0);
      idle(1);
      chk("b2b_data", 32'(data_out), 32'hAA);

`ifdef DESERIALIZER_PARITY_EN
      // Good parity on 0x55, then bad parity on 0xAA.
      send_frame(8'h55, 0, 0, 1'b0);
      idle(1);
      drive_cycle(1'b1, 1'b0, 1'b0);
      w = 8'hAA;
      for (int i = W - 1; i >= 0; i--) drive_cycle(1'b0, 1'b1, w[i]);
      drive_cycle(1'b0, 1'b1, ~(^w));
      exp_perr++;
      chk("perr_pulse", 32'(parity_err), 32'd1);
      chk("perr_no_load", 32'(load), 32'd0);
      chk("perr_data_kept", 32'(data_out), 32'h55);
      drive_cycle(1'b0, 1'b0, 1'b0);
      chk("perr_one_cycle", 32'(parity_err), 32'd0);
      chk("perr_idle", 32'(busy), 32'd0);
`endif

      // Randomized frames with random gaps and occasional aborts.
      for (int n = 0; n < 30; n++) begin
         w  = W'($urandom_range(0, (1 << W) - 1));
         ab = ($urandom_range(0, 3) == 0);
         if (ab) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(1, W - 1)) drive_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         end
         send_frame(w, 0, 2, ab);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(3);

      // End-of-run totals.
      chk("total_loads", 32'(load_seen), 32'(exp_loads));
      chk("total_frame_err", 32'(ferr_seen), 32'(exp_ferr));
      chk("total_parity_err", 32'(perr_seen), 32'(exp_perr));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, frame-start strobe.
REQ-005 SHALL have port bit_valid, input, 1, qualifies bit_in for the current cycle.
REQ-006 SHALL have port bit_in, input, 1, serial data, MSB first.
REQ-007 SHALL have port data_out, output, WIDTH, last completed word, fed to the downstream register's data_in.
REQ-008 SHALL have port load, output, 1, one-cycle strobe, fed to the downstream register's load.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when a frame is aborted by start.
REQ-011 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.

Function
REQ-012 SHALL implement the states IDLE, SHIFT, PARITY (present only when configured in) and DONE.
REQ-013 IDLE: busy=0; bit_valid is ignored; start=1 moves to SHIFT, clears the bit counter and clears the shift register.
REQ-014 SHIFT: busy=1; each cycle with bit_valid=1 shifts left (shift <= {shift[WIDTH-2:0], bit_in}) and increments the counter; cycles with bit_valid=0 hold state.
REQ-015 SHIFT: accepting the WIDTH-th bit moves to PARITY if configured, else to DONE.
REQ-016 DONE: lasts exactly one cycle; load=1 and data_out equals the assembled word in that same cycle; next state is IDLE.
REQ-017 Latency: load SHALL assert exactly one cycle after the cycle the final data bit (or parity bit) is accepted.
REQ-018 data_out SHALL change only on entry to DONE and SHALL hold its value at all other times.
REQ-019 start=1 in SHIFT or PARITY SHALL pulse frame_err for one cycle and restart the frame (counter=0, remain/return to SHIFT); the bit_in of that cycle is discarded.
REQ-020 start=1 in DONE SHALL still complete the load and move to SHIFT (back-to-back frames), with no frame_err.
REQ-021 start and bit_valid together in IDLE SHALL start the frame and discard that bit.
REQ-022 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-023 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, shift register=0, data_out=0, load=0, busy=0, frame_err=0 and parity_err=0.
REQ-024 Reset asserted mid-frame SHALL drop the partial word; no load is issued for it.
REQ-025 The first clk edge after rst deasserts SHALL behave as in IDLE.

Configuration
REQ-026 Macro DESERIALIZER_PARITY_EN defined: the PARITY state exists and takes one extra bit_valid bit after the data bits, using even parity (data XOR parity bit = 0).
REQ-027 With the macro: on a match, move to DONE; on a mismatch, pulse parity_err for one cycle, issue no load, leave data_out unchanged, and go to IDLE.
REQ-028 Macro undefined: no PARITY state; the parity_err port remains and is tied to 0; frames are WIDTH bits.

Verification
REQ-029 The bench SHALL drive WIDTH=8, macro undefined: start, then bits 01010101 on consecutive cycles -> load=1 for one cycle, data_out=8'h55, busy=0 afterwards.
REQ-030 The bench SHALL drive bits 10101010 with bit_valid=0 gaps between bits -> data_out=8'hAA, load pulses once, one cycle after the 8th bit.
REQ-031 The bench SHALL assert start after 4 bits of 0xFF, then send a full frame of 0x0F -> frame_err pulses once, data_out=8'h0F, no load for the aborted frame.
REQ-032 The bench SHALL drive rst=0 after 5 bits of 0xFF -> data_out=8'h00, busy=0, load=0 immediately; no load follows.
REQ-033 The bench SHALL assert start in the DONE cycle of 0x55, followed by 0xAA -> two load pulses, data_out 8'h55 then 8'hAA, no frame_err.
REQ-034 With DESERIALIZER_PARITY_EN, the bench SHALL send 0x55 + parity 0 -> load with data_out 8'h55; then 0xAA + parity 1 -> parity_err pulse, no load, data_out stays 8'h55.
